// File: rtl/sad_pkg.sv
// Shared sizes and FSM state type for the 4x4 block-matching SAD search engine.
package sad_pkg;
    localparam int FRAME_W = 16;
    localparam int BLK     = 4;
    localparam int SAD_W   = 12;
    localparam int NUM_POS = FRAME_W - BLK + 1;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;
endpackage

// File: rtl/sad_addr_gen.sv
// Window/pixel counters for the SAD search: dx fastest, then dy, col, row.
// Produces frame and template bank addresses plus end-of-window/end-of-frame flags.
module sad_addr_gen
    import sad_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       step,
    output logic [7:0] frame_addr,
    output logic [7:0] templ_addr,
    output logic [3:0] win_row,
    output logic [3:0] win_col,
    output logic       last_pix,
    output logic       last_win
);
    localparam logic [3:0] LAST_POS = 4'(NUM_POS - 1);
    localparam logic [1:0] LAST_OFF = 2'(BLK - 1);

    logic [1:0] dx, dy;
    logic [3:0] row, col;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dx  <= '0;
            dy  <= '0;
            row <= '0;
            col <= '0;
        end else if (clear) begin
            dx  <= '0;
            dy  <= '0;
            row <= '0;
            col <= '0;
        end else if (step) begin
            if (dx == LAST_OFF) begin
                dx <= '0;
                if (dy == LAST_OFF) begin
                    dy <= '0;
                    if (col == LAST_POS) begin
                        col <= '0;
                        row <= (row == LAST_POS) ? 4'd0 : row + 4'd1;
                    end else begin
                        col <= col + 4'd1;
                    end
                end else begin
                    dy <= dy + 2'd1;
                end
            end else begin
                dx <= dx + 2'd1;
            end
        end
    end

    // row+dy and col+dx never exceed FRAME_W-1, so the 4-bit sums cannot wrap.
    assign frame_addr = 8'(32'(row + 4'(dy)) * FRAME_W + 32'(col + 4'(dx)));
    assign templ_addr = 8'(32'(dy) * BLK + 32'(dx));
    assign win_row    = row;
    assign win_col    = col;
    assign last_pix   = (dx == LAST_OFF) && (dy == LAST_OFF);
    assign last_win   = (row == LAST_POS) && (col == LAST_POS);
endmodule

// File: rtl/sad_block_search.sv
// Exhaustive 4x4 SAD block search over a 16x16 frame; one pixel per cycle against
// combinational-read memory banks, reporting the first minimum in raster order.
module sad_block_search
    import sad_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [7:0]       frame_data,
    input  logic [7:0]       templ_data,
    output logic [7:0]       frame_addr,
    output logic [7:0]       templ_addr,
    output logic             mem_read,
    output logic             busy,
    output logic             done,
    output logic [3:0]       best_row,
    output logic [3:0]       best_col,
    output logic [SAD_W-1:0] best_sad
);
    state_t state, next_state;

    logic             clear, step, last_pix, last_win;
    logic [3:0]       win_row, win_col;
    logic [8:0]       diff9;
    logic [7:0]       diff;
    logic [SAD_W-1:0] acc, sum;

    sad_addr_gen u_addr_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .step       (step),
        .frame_addr (frame_addr),
        .templ_addr (templ_addr),
        .win_row    (win_row),
        .win_col    (win_col),
        .last_pix   (last_pix),
        .last_win   (last_win)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        clear      = 1'b0;
        step       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = SCAN;
                    clear      = 1'b1;
                end
            end
            SCAN: begin
                step = 1'b1;
                if (last_pix && last_win) next_state = DONE;
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Status outputs decode directly from the state flop, so they are glitch-free.
    assign busy     = (state == SCAN);
    assign mem_read = (state == SCAN);
    assign done     = (state == DONE);

    assign diff9 = {1'b0, frame_data} - {1'b0, templ_data};
    assign diff  = diff9[8] ? 8'(-diff9) : diff9[7:0];
    assign sum   = acc + SAD_W'(diff);

    // Strict less-than keeps the earliest window when SADs tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            best_sad <= '0;
            best_row <= '0;
            best_col <= '0;
        end else if (clear) begin
            acc      <= '0;
            best_sad <= '1;
            best_row <= '0;
            best_col <= '0;
        end else if (step) begin
            if (last_pix) begin
                acc <= '0;
                if (sum < best_sad) begin
                    best_sad <= sum;
                    best_row <= win_row;
                    best_col <= win_col;
                end
            end else begin
                acc <= sum;
            end
        end
    end
endmodule
